// File: rtl/step_playback_ctrl_if.sv
// Control/status bundle between the input stage, the playback core
// and the audio stage.
interface step_playback_ctrl_if;
    logic        Start;
    logic        Stop;
    logic [9:0]  BPM;
    logic [6:0]  Loops;
    logic [15:0] Mask;
    logic [3:0]  Step;
    logic        Step_tick;
    logic        Note_on;
    logic        Playing;
    logic [6:0]  Loop_count;
    logic        Done;

    modport master (
        output Start, Stop, BPM, Loops, Mask,
        input  Step, Step_tick, Note_on, Playing, Loop_count, Done
    );

    modport slave (
        input  Start, Stop, BPM, Loops, Mask,
        output Step, Step_tick, Note_on, Playing, Loop_count, Done
    );
endinterface

// File: rtl/step_playback_ctrl.sv
// Sequencer timing core: BPM -> step period via a 32-cycle restoring
// divider, then walks the step pattern emitting ticks, notes and loop status.
module step_playback_ctrl #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int NUM_STEPS      = 10,
    parameter int STEPS_PER_BEAT = 1,
    parameter int MIN_BPM        = 30,
    parameter int MAX_BPM        = 300
) (
    input  logic                CLOCK_50,
    input  logic                Reset,
    step_playback_ctrl_if.slave bus
);
    localparam longint NUM_L = longint'(CLK_HZ) * 64'd60;
    localparam logic [31:0] NUM = 32'(NUM_L);
    localparam logic [3:0] LAST = 4'(NUM_STEPS - 1);

    typedef enum logic [1:0] {IDLE, DIV, PLAY} state_t;

    state_t state, state_d;

    logic [31:0] den, num, rem, quot, cnt;
    logic [4:0]  bit_cnt;
    logic [6:0]  loops_q;

    logic [3:0]  step_q, step_d;
    logic [6:0]  lc_q, lc_d;
    logic        tick_q, tick_d;
    logic        note_q, note_d;
    logic        done_q, done_d;
    logic        play_q, play_d;

    logic        accept, div_last, fire, at_last, finish;
    logic [6:0]  lc_inc;
    logic [9:0]  bpm_c;
    logic [32:0] rem_s;
    logic        ge;
    logic [31:0] rem_sub, rem_n, quot_n;

    function automatic logic [31:0] reload(input logic [31:0] p);
        return (p == 32'd0) ? 32'd0 : p - 32'd1;
    endfunction

    assign accept   = (state == IDLE) && bus.Start && !bus.Stop;
    assign div_last = (state == DIV) && (bit_cnt == 5'd31);
    assign fire     = (state == PLAY) && (cnt == 32'd0);
    assign at_last  = (step_q == LAST);
    assign lc_inc   = (lc_q == 7'd127) ? lc_q : lc_q + 7'd1;
    assign finish   = fire && at_last && (loops_q != 7'd0)
                      && (lc_inc >= loops_q);

    assign bpm_c = (bus.BPM < 10'(MIN_BPM)) ? 10'(MIN_BPM) :
                   (bus.BPM > 10'(MAX_BPM)) ? 10'(MAX_BPM) : bus.BPM;

    // One restoring-division step: shift in next numerator bit, try subtract.
    assign rem_s   = {rem, num[31]};
    assign ge      = (rem_s >= {1'b0, den});
    assign rem_sub = rem_s[31:0] - den;
    assign rem_n   = ge ? rem_sub : rem_s[31:0];
    assign quot_n  = {quot[30:0], ge};

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (accept) state_d = DIV;
            DIV: begin
                if (bus.Stop)     state_d = IDLE;
                else if (div_last) state_d = PLAY;
            end
            PLAY: begin
                if (bus.Stop || finish) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        step_d = step_q;
        lc_d   = lc_q;
        tick_d = 1'b0;
        done_d = 1'b0;
        play_d = (state_d == DIV) || (state_d == PLAY);
        unique case (state)
            IDLE: begin
                if (accept) begin
                    step_d = 4'd0;
                    lc_d   = 7'd0;
                end
            end
            DIV: begin
                if (bus.Stop) begin
                    step_d = 4'd0;
                end else if (div_last) begin
                    step_d = 4'd0;
                    tick_d = 1'b1;
                end
            end
            PLAY: begin
                if (bus.Stop) begin
                    step_d = 4'd0;
                end else if (fire && !at_last) begin
                    step_d = step_q + 4'd1;
                    tick_d = 1'b1;
                end else if (fire) begin
                    lc_d   = lc_inc;
                    step_d = 4'd0;
                    done_d = finish;
                    tick_d = !finish;
                end
            end
            default: step_d = 4'd0;
        endcase
        note_d = tick_d & bus.Mask[step_d];
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            den     <= '0;
            num     <= '0;
            rem     <= '0;
            quot    <= '0;
            cnt     <= '0;
            bit_cnt <= '0;
            loops_q <= '0;
            step_q  <= '0;
            lc_q    <= '0;
            tick_q  <= 1'b0;
            note_q  <= 1'b0;
            done_q  <= 1'b0;
            play_q  <= 1'b0;
        end else begin
            step_q <= step_d;
            lc_q   <= lc_d;
            tick_q <= tick_d;
            note_q <= note_d;
            done_q <= done_d;
            play_q <= play_d;
            if (accept) begin
                den     <= 32'(bpm_c) * 32'(STEPS_PER_BEAT);
                loops_q <= bus.Loops;
                num     <= NUM;
                rem     <= '0;
                quot    <= '0;
                bit_cnt <= '0;
            end else if (state == DIV) begin
                rem     <= rem_n;
                num     <= {num[30:0], 1'b0};
                quot    <= quot_n;
                bit_cnt <= bit_cnt + 5'd1;
                if (div_last) cnt <= reload(quot_n);
            end else if (state == PLAY) begin
                cnt <= fire ? reload(quot) : cnt - 32'd1;
            end
        end
    end

    assign bus.Step       = step_q;
    assign bus.Step_tick  = tick_q;
    assign bus.Note_on    = note_q;
    assign bus.Playing    = play_q;
    assign bus.Loop_count = lc_q;
    assign bus.Done       = done_q;
endmodule

// File: tb/tb_step_playback_ctrl.sv
// Directed bench for step_playback_ctrl at CLK_HZ=1000, 8 steps,
// one step per beat.
module tb_step_playback_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    step_playback_ctrl_if bus();

    step_playback_ctrl #(
        .CLK_HZ(1000),
        .NUM_STEPS(8),
        .STEPS_PER_BEAT(1),
        .MIN_BPM(30),
        .MAX_BPM(300)
    ) dut (
        .CLOCK_50(clk),
        .Reset(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cur, ticks, notes, dones;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // {Step, Step_tick, Note_on, Playing, Loop_count, Done}
    function automatic logic [31:0] outs();
        return {17'd0, bus.Step, bus.Step_tick, bus.Note_on,
                bus.Playing, bus.Loop_count, bus.Done};
    endfunction

    task automatic step1();
        @(posedge clk);
        #1;
        cur++;
        if (bus.Step_tick) ticks++;
        if (bus.Note_on)   notes++;
        if (bus.Done)      dones++;
    endtask

    task automatic go(input int c);
        while (cur < c) step1();
    endtask

    task automatic start_play(input logic [9:0] bpm,
                              input logic [6:0] loops);
        bus.BPM   = bpm;
        bus.Loops = loops;
        bus.Start = 1'b1;
        cur   = 0;
        ticks = 0;
        notes = 0;
        dones = 0;
        step1();
        bus.Start = 1'b0;
    endtask

    task automatic stop_play();
        bus.Stop = 1'b1;
        step1();
        bus.Stop = 1'b0;
    endtask

    initial begin
        bus.Start = 1'b0;
        bus.Stop  = 1'b0;
        bus.BPM   = 10'd120;
        bus.Loops = 7'd1;
        bus.Mask  = 16'h00ff;
        cur = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", outs(), 32'd0);
        rst = 1'b0;
        step1();

        // 1: BPM 120, one pass, period 500
        start_play(10'd120, 7'd1);
        check("t1_playing_c1", {31'd0, bus.Playing}, 32'd1);
        bus.BPM = 10'd30;
        go(32);
        check("t1_no_tick_c32", {31'd0, bus.Step_tick}, 32'd0);
        go(33);
        check("t1_first_tick", outs(), {17'd0, 4'd0, 3'b111, 7'd0, 1'b0});
        go(532);
        check("t1_no_tick_c532", {31'd0, bus.Step_tick}, 32'd0);
        go(533);
        check("t1_step1", {28'd0, bus.Step}, 32'd1);
        check("t1_tick_c533", {31'd0, bus.Step_tick}, 32'd1);
        go(3533);
        check("t1_step7", {28'd0, bus.Step}, 32'd7);
        go(4032);
        check("t1_done_early", {31'd0, bus.Done}, 32'd0);
        go(4033);
        check("t1_done", outs(), {17'd0, 4'd0, 3'b000, 7'd1, 1'b1});
        check("t1_ticks", ticks, 32'd8);
        check("t1_notes", notes, 32'd8);
        go(4034);
        check("t1_done_pulse", {31'd0, bus.Done}, 32'd0);

        // 2: mask 0x0005, two passes at BPM 300 (period 200)
        bus.Mask = 16'h0005;
        start_play(10'd300, 7'd2);
        go(433);
        check("t2_step2_note", {27'd0, bus.Step, bus.Note_on}, {27'd0, 4'd2, 1'b1});
        go(633);
        check("t2_step3_note", {27'd0, bus.Step, bus.Note_on}, {27'd0, 4'd3, 1'b0});
        go(1633);
        check("t2_wrap", outs(), {17'd0, 4'd0, 3'b111, 7'd1, 1'b0});
        go(3233);
        check("t2_done", outs(), {17'd0, 4'd0, 3'b000, 7'd2, 1'b1});
        check("t2_ticks", ticks, 32'd16);
        check("t2_notes", notes, 32'd4);
        check("t2_dones", dones, 32'd1);

        // 3: clamping
        bus.Mask = 16'h00ff;
        start_play(10'd5, 7'd1);
        go(2032);
        check("t3_lo_no_tick", {31'd0, bus.Step_tick}, 32'd0);
        go(2033);
        check("t3_lo_tick", {27'd0, bus.Step, bus.Step_tick}, {27'd0, 4'd1, 1'b1});
        stop_play();
        check("t3_lo_stop", {31'd0, bus.Playing}, 32'd0);
        start_play(10'd999, 7'd1);
        go(232);
        check("t3_hi_no_tick", {31'd0, bus.Step_tick}, 32'd0);
        go(233);
        check("t3_hi_tick", {27'd0, bus.Step, bus.Step_tick}, {27'd0, 4'd1, 1'b1});
        stop_play();

        // 4: infinite loops, Start during PLAY ignored
        start_play(10'd300, 7'd0);
        go(1633);
        check("t4_wrap", outs(), {17'd0, 4'd0, 3'b111, 7'd1, 1'b0});
        go(1700);
        bus.Start = 1'b1;
        step1();
        bus.Start = 1'b0;
        go(1800);
        check("t4_start_ignored", {25'd0, bus.Loop_count}, 32'd1);
        go(4833);
        check("t4_pass3", outs(), {17'd0, 4'd0, 3'b111, 7'd3, 1'b0});
        check("t4_no_done", dones, 32'd0);
        stop_play();
        check("t4_lc_hold", {25'd0, bus.Loop_count}, 32'd3);

        // 5: Stop mid-pattern, Start+Stop together
        start_play(10'd300, 7'd0);
        check("t5_lc_cleared", {25'd0, bus.Loop_count}, 32'd0);
        go(633);
        check("t5_step3", {28'd0, bus.Step}, 32'd3);
        go(700);
        stop_play();
        check("t5_stopped", outs(), 32'd0);
        bus.Start = 1'b1;
        bus.Stop  = 1'b1;
        step1();
        bus.Start = 1'b0;
        bus.Stop  = 1'b0;
        check("t5_both_c1", {31'd0, bus.Playing}, 32'd0);
        go(cur + 40);
        check("t5_both_later", {31'd0, bus.Playing}, 32'd0);

        // 6: async reset mid-DIV and mid-PLAY
        start_play(10'd120, 7'd1);
        go(10);
        rst = 1'b1;
        #2;
        check("t6_rst_div", outs(), 32'd0);
        rst = 1'b0;
        step1();
        start_play(10'd120, 7'd1);
        go(33);
        check("t6_restart_tick", outs(), {17'd0, 4'd0, 3'b111, 7'd0, 1'b0});
        go(600);
        rst = 1'b1;
        #2;
        check("t6_rst_play", outs(), 32'd0);
        rst = 1'b0;
        step1();
        start_play(10'd120, 7'd1);
        go(32);
        check("t6_re2_no_tick", {31'd0, bus.Step_tick}, 32'd0);
        go(33);
        check("t6_re2_tick", {31'd0, bus.Step_tick}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
